// File: rtl/o_sram_writer_if.sv
// Bundles the upstream vector handshake (valid/ready/data) with the
// OSRAM write port (we/addr/wdata/gnt). The writer uses the master side;
// whoever plays the PE and the OSRAM uses the slave side.
interface o_sram_writer_if #(
    parameter int EMBED_DIM = 64,
    parameter int ELEM_W    = 8,
    parameter int SRAM_W    = 128,
    parameter int ADDR_W    = 16
);
    // Upstream vector handshake
    logic                        vld_in;
    logic                        rdy_out;
    logic [EMBED_DIM*ELEM_W-1:0] o_in;

    // OSRAM write port
    logic                        sram_we;
    logic [ADDR_W-1:0]           sram_addr;
    logic [SRAM_W-1:0]           sram_wdata;
    logic                        sram_gnt;

    modport master (
        input  vld_in,
        input  o_in,
        input  sram_gnt,
        output rdy_out,
        output sram_we,
        output sram_addr,
        output sram_wdata
    );

    modport slave (
        output vld_in,
        output o_in,
        output sram_gnt,
        input  rdy_out,
        input  sram_we,
        input  sram_addr,
        input  sram_wdata
    );
endinterface

// File: rtl/o_sram_writer.sv
// Output-side OSRAM writer. Accepts whole output vectors from a PE into a
// small register FIFO, then slices the FIFO head into SRAM_W-wide beats and
// writes them to consecutive OSRAM addresses. One start pulse arms a batch of
// num_rows vectors; a single-cycle done pulse closes it.
module o_sram_writer #(
    parameter int EMBED_DIM  = 64,
    parameter int ELEM_W     = 8,
    parameter int SRAM_W     = 128,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 16,
    parameter int ROWS_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr_in,
    input  logic [ROWS_W-1:0]    num_rows_in,
    o_sram_writer_if.master      bus,
    output logic                 busy,
    output logic                 done
);

    localparam int VEC_W  = EMBED_DIM * ELEM_W;
    localparam int BEATS  = VEC_W / SRAM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] BEATS_A   = ADDR_W'(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Batch parameters and progress counters
    logic [ADDR_W-1:0]  r_base;
    logic [ROWS_W-1:0]  r_num_rows;
    logic [ROWS_W-1:0]  r_accepted;
    logic [ROWS_W-1:0]  r_row;
    logic [BEAT_W-1:0]  r_beat;

    // Vector FIFO
    logic [VEC_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_rdy;
    logic               w_we;
    logic               w_push;
    logic               w_beat_gnt;
    logic               w_last_beat;
    logic               w_pop;
    logic               w_last_row;
    logic               w_start_acc;
    logic [VEC_W-1:0]   w_head;
    logic [SRAM_W-1:0]  w_beat_data [BEATS];
    logic [ADDR_W-1:0]  w_addr;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = w_rdy && bus.vld_in;
    assign w_beat_gnt  = w_we && bus.sram_gnt;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_pop       = w_beat_gnt && w_last_beat;
    assign w_last_row  = ((r_row + ROWS_W'(1)) == r_num_rows);
    assign w_start_acc = (r_state == ST_IDLE) && start;

    // Head vector split into beats; beat 0 is the least significant slice.
    assign w_head = r_mem[r_rd_ptr];
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_slice
            assign w_beat_data[gi] = w_head[gi*SRAM_W +: SRAM_W];
        end
    endgenerate

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign w_addr = r_base + (ADDR_W'(r_row) * BEATS_A) + ADDR_W'(r_beat);

    // Address/data are forced to zero whenever no write is requested so that
    // the bus idles at a clean value (and reads zero straight out of reset).
    assign bus.rdy_out    = w_rdy;
    assign bus.sram_we    = w_we;
    assign bus.sram_addr  = w_we ? w_addr : '0;
    assign bus.sram_wdata = w_we ? w_beat_data[r_beat] : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs; everything here depends on registered
    // state only except the RUN->DONE decision, which needs the grant.
    always_comb begin
        w_state_next = r_state;
        w_rdy        = 1'b0;
        w_we         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_rows_in == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                w_rdy = !w_full && (r_accepted < r_num_rows);
                w_we  = !w_empty;
                if (w_we && bus.sram_gnt && w_last_beat && w_last_row) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch batch parameters on start; track accepted vectors, written rows
    // and the beat within the current row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_num_rows <= '0;
            r_accepted <= '0;
            r_row      <= '0;
            r_beat     <= '0;
        end else if (w_start_acc) begin
            r_base     <= base_addr_in;
            r_num_rows <= num_rows_in;
            r_accepted <= '0;
            r_row      <= '0;
            r_beat     <= '0;
        end else begin
            if (w_push) begin
                r_accepted <= r_accepted + ROWS_W'(1);
            end
            if (w_beat_gnt) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    r_row  <= r_row + ROWS_W'(1);
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    // FIFO pointers and occupancy; a new batch starts from an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_start_acc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count,
    // so the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.o_in;
        end
    end

endmodule

// File: doc/o_sram_writer.md
# o_sram_writer

Output-side writer for the AURA backend. It accepts scaled output vectors from a PE over the PE's output valid/ready handshake and buffers them in a small FIFO. It serializes each vector into fixed-width beats and writes them into OSRAM at consecutive addresses. A single `start` pulse arms it for one query-row batch, and a one-cycle `done` pulse closes the batch.

## Interface
- `EMBED_DIM`, default 64: elements per output vector.
- `ELEM_W`, default 8: bits per element.
- `SRAM_W`, default 128: OSRAM write-port width. Must divide `EMBED_DIM*ELEM_W`. `BEATS = EMBED_DIM*ELEM_W/SRAM_W` (default 4).
- `FIFO_DEPTH`, default 2: vector buffer entries, power of two.
- `ADDR_W`, default 16: OSRAM address width.
- `ROWS_W`, default 8: width of the row-count field.

Ports:
- `clk` input, 1: system clock.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: batch start pulse. Sampled only in IDLE.
- `base_addr_in` input, ADDR_W: first OSRAM word address of the batch.
- `num_rows_in` input, ROWS_W: vectors in the batch.
- `vld_in` input, 1: upstream vector valid (the PE's `output_valid`).
- `rdy_out` output, 1: ready to upstream (drives the PE's `O_sram_rdy`).
- `o_in` input, EMBED_DIM*ELEM_W: output vector. Element 0 is in the LSBs.
- `sram_we` output, 1: OSRAM write request.
- `sram_addr` output, ADDR_W: write address.
- `sram_wdata` output, SRAM_W: write data.
- `sram_gnt` input, 1: OSRAM accepts the current write this cycle.
- `busy` output, 1: high in RUN and DONE.
- `done` output, 1: one-cycle batch-complete pulse.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start=1` latches `base_addr_in` and `num_rows_in`, clears the accept count, write-row count, beat count and FIFO, and goes to RUN.
  - If the latched `num_rows_in` is 0, go to DONE instead of RUN.
- **RUN:**
  - `rdy_out = !fifo_full && (accepted < num_rows)`.
  - A vector is pushed on `vld_in && rdy_out`.
  - `rdy_out` does not depend on a same-cycle pop: a full FIFO stalls upstream even if it drains that cycle.
  - `sram_we = !fifo_empty`.
  - `sram_wdata` = beat `beat` of the FIFO head, i.e. bits `[beat*SRAM_W +: SRAM_W]`.
  - `sram_addr = base + row*BEATS + beat`, computed modulo 2^ADDR_W (wraps silently).
  - On `sram_we && sram_gnt`:
    - If `beat < BEATS-1`, increment `beat`.
    - Otherwise clear `beat`, pop the head and increment `row`.
  - While `sram_we && !sram_gnt`, `sram_we`, `sram_addr` and `sram_wdata` hold stable.
  - When the final beat of row `num_rows-1` is granted, go to DONE.
- **DONE:**
  - `done=1`, `rdy_out=0`, `sram_we=0` for exactly one cycle, then IDLE.
- **Other states:** `rdy_out=0` and `sram_we=0` outside RUN.
- **Ignored inputs:**
  - `start` is ignored in RUN and DONE.
  - `vld_in` while `rdy_out=0` is ignored. Upstream holds its data.
- **Reset:** asynchronous. Takes effect mid-batch: the FIFO, counters and latched batch parameters clear, the batch is abandoned with no `done`, and the state goes to IDLE.

## Timing
- **Reset values:** state IDLE; `rdy_out=0`, `sram_we=0`, `sram_addr=0`, `sram_wdata=0`, `busy=0`, `done=0`.
- **Start latency:** `start` at edge N gives RUN and `rdy_out=1` in cycle N+1.
- **Push to write latency:** a vector pushed at edge N gives `sram_we=1` for its beat 0 in cycle N+1 (registered FIFO, no bypass).
- **Throughput:** with `sram_gnt` tied high, one vector per BEATS cycles. Upstream can stay ahead by up to FIFO_DEPTH vectors.
- **Done:** the last beat granted at edge M gives `done=1` in cycle M+1 and IDLE in cycle M+2.
- **Combinational paths:** `sram_we`, `sram_addr` and `sram_wdata` are combinational from registered state only. There is no combinational path from `sram_gnt` or `vld_in` to any output.

## Test plan
- **Single row, no stall:**
  - Stimulus: `start` with base=0x0100, rows=1; push vector with bytes 0x00..0x3F; `sram_gnt=1`.
  - Required: 4 writes at 0x0100..0x0103. The first has `wdata` = bytes 0x0F..0x00 (LSB=0x00). `done` one cycle after the 4th grant.
- **Backpressure fill:**
  - Stimulus: rows=4, `sram_gnt=0`, `vld_in` held high.
  - Required: exactly 2 pushes, then `rdy_out=0`. `sram_we=1` with addr=base and data stable every cycle.
  - Stimulus: release `sram_gnt`.
  - Required: 16 writes in order, `done` asserted.
- **Random gnt/vld stalls:**
  - Stimulus: rows=8, random `sram_gnt` and `vld_in`.
  - Required: 32 writes. Each addr=base+k, each data matches the scoreboard, no duplicate or dropped beats. `rdy_out=0` after the 8th accept.
- **Address wrap and zero rows:**
  - Stimulus: base=0xFFFE, rows=1.
  - Required: addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Stimulus: rows=0.
  - Required: `done` in the cycle after `start`, with no writes and `rdy_out` never high.
- **Mid-batch reset:**
  - Stimulus: assert `rst` after 5 of 16 beats.
  - Required: all outputs at reset values immediately, no `done`. A new `start` runs a full batch correctly.
- **Ignored start:**
  - Stimulus: `start` pulsed during RUN with different parameters.
  - Required: the current batch's addresses and row count are unchanged.
